// File: rtl/io_input_pkg.sv
`default_nettype none
// ============================================================================
// io_input_pkg : shared widths and defaults for the board input conditioner
// Rev 1.0
// ============================================================================
package io_input_pkg;

  localparam int SW_W                    = 32;
  localparam int NUM_BTN                 = 4;
  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_ch.sv
`default_nettype none
// ============================================================================
// debounce_ch : one button -- invert, synchronize, debounce, press pulse
// Rev 1.0
// ============================================================================
module debounce_ch
  import io_input_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_i,
  output logic level_o,
  output logic press_o
);

  localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [0:0] ST_STABLE   = 1'b0;
  localparam logic [0:0] ST_COUNTING = 1'b1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   level_q, level_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   press_q, press_d;
  logic [0:0]             state;

  assign s = sync_q[SYNC_STAGES-1];

  // The state is implied by whether the synchronized input disagrees with q.
  assign state = (s != level_q) ? ST_COUNTING : ST_STABLE;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    case (state)
      ST_COUNTING: begin
        if (cnt_q == CNT_LAST) begin
          level_d = s;
          press_d = s;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Reset loads the released level into the synchronizer (0 after inversion).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], ~btn_n_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/io_input_cond.sv
`default_nettype none
// ============================================================================
// io_input_cond : switch synchronizers and debounced buttons for the core
// Rev 1.0
// ============================================================================
module io_input_cond
  import io_input_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SW_W-1:0]    sw_raw,
  input  logic [NUM_BTN-1:0] btn_n_raw,
  output logic [SW_W-1:0]    io_sw,
  output logic [NUM_BTN-1:0] io_btn,
  output logic [NUM_BTN-1:0] btn_press
);

  // Switches are level inputs read by software, so they are only synchronized.
  for (genvar g = 0; g < SW_W; g++) begin : g_sw_bit
    logic [SYNC_STAGES-1:0] chain_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        chain_q <= '0;
      end else begin
        chain_q <= {chain_q[SYNC_STAGES-2:0], sw_raw[g]};
      end
    end

    assign io_sw[g] = chain_q[SYNC_STAGES-1];
  end

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    debounce_ch #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_n_i (btn_n_raw[b]),
      .level_o (io_btn[b]),
      .press_o (btn_press[b])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_io_input_cond.sv
`default_nettype none
// ============================================================================
// tb_io_input_cond : directed stimulus, history-window model, literal pins
// Rev 1.0
// ============================================================================
module tb_io_input_cond;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] sw_raw;
  logic [3:0]  btn_n_raw;
  logic [31:0] io_sw;
  logic [3:0]  io_btn;
  logic [3:0]  btn_press;

  io_input_cond #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_raw    (sw_raw),
    .btn_n_raw (btn_n_raw),
    .io_sw     (io_sw),
    .io_btn    (io_btn),
    .btn_press (btn_press)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Model: an output follows the raw input sampled SYNC edges ago (0 if a reset
  // edge intervened); a button level flips once the last DEB synchronized
  // samples all disagree with it.
  int       since_rst = 0;
  bit [31:0] sw_hist [SYNC];
  bit [3:0]  pr_hist [SYNC];
  bit [3:0]  s_hist  [DEB];
  bit [3:0]  q_m;
  bit [3:0]  s_now;
  bit        agree;
  bit [31:0] exp_sw;
  bit [3:0]  exp_btn;
  bit [3:0]  exp_press;
  bit        model_ok = 1'b0;

  always @(posedge clk) begin
    for (int k = SYNC - 1; k > 0; k--) begin
      sw_hist[k] = sw_hist[k-1];
      pr_hist[k] = pr_hist[k-1];
    end
    sw_hist[0] = sw_raw;
    pr_hist[0] = ~btn_n_raw;
    exp_press  = '0;
    if (!rst_n) begin
      since_rst = 0;
      q_m       = '0;
      s_now     = '0;
    end else begin
      if (since_rst < 1000) since_rst++;
      for (int b = 0; b < 4; b++) begin
        agree = 1'b1;
        for (int k = 0; k < DEB; k++) begin
          if (s_hist[k][b] == q_m[b]) agree = 1'b0;
        end
        if (agree) begin
          if (!q_m[b]) exp_press[b] = 1'b1;
          q_m[b] = ~q_m[b];
        end
      end
      s_now = (since_rst >= SYNC) ? pr_hist[SYNC-1] : 4'b0;
    end
    for (int k = DEB - 1; k > 0; k--) s_hist[k] = s_hist[k-1];
    s_hist[0] = s_now;
    exp_sw    = (since_rst >= SYNC) ? sw_hist[SYNC-1] : 32'b0;
    exp_btn   = q_m;
    model_ok  = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("model_io_sw",     io_sw,            exp_sw);
      check("model_io_btn",    {28'b0, io_btn},    {28'b0, exp_btn});
      check("model_btn_press", {28'b0, btn_press}, {28'b0, exp_press});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] sw_tab [4];

  initial begin
    sw_tab[0] = 32'hA5A5_0F0F;
    sw_tab[1] = 32'h0000_0000;
    sw_tab[2] = 32'hFFFF_FFFF;
    sw_tab[3] = 32'h8000_0001;

    rst_n     = 1'b0;
    sw_raw    = 32'hFFFF_FFFF;
    btn_n_raw = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rst_io_sw",     io_sw,             32'h0);
      check("rst_io_btn",    {28'b0, io_btn},    32'h0);
      check("rst_btn_press", {28'b0, btn_press}, 32'h0);
    end

    rst_n     = 1'b1;
    sw_raw    = 32'd2;
    btn_n_raw = 4'b1111;
    tick(1);
    check("sw_lat_edge1", io_sw, 32'd0);
    tick(1);
    check("sw_lat_edge2", io_sw, 32'd2);

    for (int i = 0; i < 4; i++) begin
      sw_raw = sw_tab[i];
      tick(1);
      tick(1);
      check("sw_table", io_sw, sw_tab[i]);
    end

    // Clean press on button 0
    btn_n_raw = 4'b1110;
    tick(5);
    check("press0_edge5", {28'b0, io_btn}, 32'h0);
    tick(1);
    check("press0_edge6_btn",   {28'b0, io_btn},    32'h1);
    check("press0_edge6_pulse", {28'b0, btn_press}, 32'h1);
    tick(1);
    check("press0_edge7_pulse", {28'b0, btn_press}, 32'h0);
    check("press0_edge7_btn",   {28'b0, io_btn},    32'h1);

    // Bounce on button 1: low 3, high 1, then low held
    btn_n_raw = 4'b1100;
    tick(3);
    btn_n_raw = 4'b1110;
    tick(1);
    btn_n_raw = 4'b1100;
    tick(5);
    check("bounce_edge5_btn", {28'b0, io_btn}, 32'h1);
    tick(1);
    check("bounce_edge6_btn",   {28'b0, io_btn},    32'h3);
    check("bounce_edge6_pulse", {28'b0, btn_press}, 32'h2);
    tick(1);
    check("bounce_edge7_pulse", {28'b0, btn_press}, 32'h0);

    // Simultaneous release of buttons 0 and 1
    btn_n_raw = 4'b1111;
    tick(5);
    check("release_edge5_btn", {28'b0, io_btn}, 32'h3);
    tick(1);
    check("release_edge6_btn",   {28'b0, io_btn},    32'h0);
    check("release_edge6_pulse", {28'b0, btn_press}, 32'h0);

    // Reset in the middle of qualifying button 2
    btn_n_raw = 4'b1011;
    tick(3);
    rst_n = 1'b0;
    tick(1);
    check("midrst_btn", {28'b0, io_btn}, 32'h0);
    rst_n = 1'b1;
    tick(5);
    check("midrst_edge5_btn", {28'b0, io_btn}, 32'h0);
    tick(1);
    check("midrst_edge6_btn",   {28'b0, io_btn},    32'h4);
    check("midrst_edge6_pulse", {28'b0, btn_press}, 32'h4);

    // Three buttons pressed together pulse in the same cycle
    btn_n_raw = 4'b0000;
    tick(6);
    check("simul_btn",   {28'b0, io_btn},    32'hF);
    check("simul_pulse", {28'b0, btn_press}, 32'hB);
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
